// File: rtl/newton_quot_denorm_pkg.sv
// rtl/newton_quot_denorm_pkg.sv - shared widths for the Newton divider and its quotient denormaliser
package newton_quot_denorm_pkg;

    localparam int EXP_W         = 6;
    localparam int DSIZE_DEFAULT = 24;

    // Divider mantissa Q is 2*DSIZE bits wide with 2*DSIZE-2 fraction bits
    function automatic int q_width(input int dsize);
        return 2 * dsize;
    endfunction

    // Shift amount spans 0 .. 2*DSIZE-2+32, so it needs this many bits
    function automatic int shift_width(input int dsize);
        return $clog2(2 * dsize + 31);
    endfunction

    localparam int Q_W_DEFAULT     = q_width(DSIZE_DEFAULT);
    localparam int SHIFT_W_DEFAULT = shift_width(DSIZE_DEFAULT);

endpackage

// File: rtl/newton_quot_denorm_if.sv
// rtl/newton_quot_denorm_if.sv - divider-result input and quotient output handshake bundle
interface newton_quot_denorm_if
    import newton_quot_denorm_pkg::*;
#(
    parameter int DSIZE = 24,
    parameter int FBITS = 8
);
    logic [q_width(DSIZE)-1:0] q_in;
    logic [EXP_W-1:0]          exp_in;
    logic                      q_valid;
    logic                      in_rdy;
    logic [DSIZE+FBITS-1:0]    quo;
    logic                      sat;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output q_in, exp_in, q_valid, out_ready,
        input  in_rdy, quo, sat, out_valid
    );

    modport slave (
        input  q_in, exp_in, q_valid, out_ready,
        output in_rdy, quo, sat, out_valid
    );
endinterface

// File: rtl/newton_quot_fifo.sv
// rtl/newton_quot_fifo.sv - result FIFO with drop detection for the quotient denormaliser
module newton_quot_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;

    // Extra pointer bit separates full from empty when the index bits match
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        count    = wr_ptr - rd_ptr;
        pop      = !empty && pop_ready;
        wr_en    = push && (!full || pop);
        rd_valid = !empty;
        rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    // Storage is not reset; the pointers alone decide what is visible
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer advance on accepted push and pop
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky drop flag; a new drop outranks a clear in the same cycle
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (push && full && !pop) begin
            drop_err <= 1'b1;
        end else if (clr_err) begin
            drop_err <= 1'b0;
        end
    end

endmodule

// File: rtl/newton_quot_denorm.sv
// rtl/newton_quot_denorm.sv - shift, round and saturate the Newton divider quotient into a FIFO
module newton_quot_denorm
    import newton_quot_denorm_pkg::*;
#(
    parameter int DSIZE = 24,
    parameter int FBITS = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 rst_n,
    newton_quot_denorm_if.slave  bus,
    input  logic                 clr_err,
    output logic                 drop_err
);
    localparam int QW     = q_width(DSIZE);
    localparam int SW     = shift_width(DSIZE);
    localparam int OW     = DSIZE + FBITS;
    localparam int AW     = $clog2(DEPTH);
    localparam int S_BASE = QW - 2 - FBITS;

    logic            s1_v;
    logic [QW-1:0]   s1_q;
    logic [SW-1:0]   s1_s;
    logic            s2_v;
    logic [QW-1:0]   s2_val;
    logic            s2_r;
    logic [SW-1:0]   s_calc;
    logic [QW-1:0]   r_shift;
    logic [QW:0]     w;
    logic            sat_c;
    logic [OW-1:0]   quo_c;
    logic [OW:0]     rd_data;
    logic [AW:0]     count;
    logic [AW+1:0]   occ;
    logic            in_rdy_q;

    // Right-shift amount; exp_in is signed so the result never goes negative
    always_comb s_calc = SW'(S_BASE) - SW'($signed(bus.exp_in));

    // Stage 1: capture the mantissa and its shift amount
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_q <= '0;
            s1_s <= '0;
        end else begin
            s1_v <= bus.q_valid;
            if (bus.q_valid) begin
                s1_q <= bus.q_in;
                s1_s <= s_calc;
            end
        end
    end

    // Bit just below the kept LSB; oversized shifts naturally yield zero
    always_comb r_shift = (s1_s == '0) ? '0 : (s1_q >> (s1_s - SW'(1)));

    // Stage 2: truncated value and round bit
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s2_v   <= 1'b0;
            s2_val <= '0;
            s2_r   <= 1'b0;
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_val <= s1_q >> s1_s;
                s2_r   <= r_shift[0];
            end
        end
    end

    // Stage 3: round half up, then clamp to the output range
    always_comb begin
        w     = (QW+1)'(s2_val) + (QW+1)'(s2_r);
        sat_c = (w >> OW) != '0;
        quo_c = sat_c ? '1 : OW'(w);
    end

    newton_quot_fifo #(
        .WIDTH (OW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .rst_n     (rst_n),
        .push      (s2_v),
        .push_data ({sat_c, quo_c}),
        .pop_ready (bus.out_ready),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .rd_valid  (bus.out_valid),
        .count     (count),
        .drop_err  (drop_err)
    );

    assign bus.quo = rd_data[OW-1:0];
    assign bus.sat = rd_data[OW];

    // Next-cycle occupancy ignoring pops, so a high in_rdy always has room behind it
    always_comb occ = (AW+2)'(count) + (AW+2)'(s1_v) + (AW+2)'(s2_v) + (AW+2)'(bus.q_valid);

    // Registered ready; low throughout reset
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            in_rdy_q <= 1'b0;
        end else begin
            in_rdy_q <= (occ < (AW+2)'(DEPTH));
        end
    end

    assign bus.in_rdy = in_rdy_q;

endmodule

// File: tb/tb_newton_quot_denorm.sv
// tb/tb_newton_quot_denorm.sv - scoreboard bench for newton_quot_denorm
module tb_newton_quot_denorm;

    localparam int DSIZE = 24;
    localparam int FBITS = 8;
    localparam int DEPTH = 4;

    logic clock;
    logic rst_n;
    logic clr_err;
    logic drop_err;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q [$];
    logic [32:0] m_exp;

    newton_quot_denorm_if #(.DSIZE(DSIZE), .FBITS(FBITS)) bus ();

    newton_quot_denorm #(.DSIZE(DSIZE), .FBITS(FBITS), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .bus      (bus),
        .clr_err  (clr_err),
        .drop_err (drop_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Quotient Q*2^e with Q holding 46 fraction bits, expressed with 8 fraction bits:
    // floor(Q * 2^(e-38) + 1/2), clamped to 32 bits.
    function automatic logic [32:0] model(input logic [47:0] q, input int e);
        int k;
        logic [127:0] acc;
        k   = 38 - e;
        acc = ({80'd0, q} + (128'd1 << (k - 1))) >> k;
        if (acc >= 128'h1_0000_0000) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, acc[31:0]};
    endfunction

    function automatic logic [47:0] rand_q();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return 48'(r) >> $urandom_range(0, 47);
    endfunction

    task automatic step(input logic v, input logic [47:0] q, input int e, input logic expect_it);
        @(posedge clock);
        #1;
        bus.q_valid = v;
        bus.q_in    = q;
        bus.exp_in  = 6'(e);
        if (v && expect_it) exp_q.push_back(model(q, e));
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || bus.out_valid); i++) step(1'b0, '0, 0, 1'b0);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: compares every handshaken output against the queue head
    always @(negedge clock) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", {bus.sat, bus.quo});
            end else begin
                m_exp = exp_q.pop_front();
                check("quo", 64'(bus.quo), 64'(m_exp[31:0]));
                check("sat", 64'(bus.sat), 64'(m_exp[32]));
            end
        end
    end

    initial begin
        int misses;
        logic v;
        logic [47:0] rq;
        int re;

        rst_n         = 1'b0;
        clr_err       = 1'b0;
        bus.q_valid   = 1'b0;
        bus.q_in      = '0;
        bus.exp_in    = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_quo", 64'(bus.quo), 64'd0);
        check("rst_sat", 64'(bus.sat), 64'd0);
        check("rst_in_rdy", 64'(bus.in_rdy), 64'd0);
        check("rst_drop_err", 64'(drop_err), 64'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        check("in_rdy_after_release", 64'(bus.in_rdy), 64'd1);

        // Latency: result visible exactly three cycles after the pulse
        bus.out_ready = 1'b1;
        step(1'b1, 48'h1 << 46, 0, 1'b1);
        step(1'b0, '0, 0, 1'b0);
        check("lat_c1_valid", 64'(bus.out_valid), 64'd0);
        step(1'b0, '0, 0, 1'b0);
        check("lat_c2_valid", 64'(bus.out_valid), 64'd0);
        step(1'b0, '0, 0, 1'b0);
        check("lat_c3_valid", 64'(bus.out_valid), 64'd1);
        check("lat_c3_quo", 64'(bus.quo), 64'h100);

        // Directed vectors back to back: round-up, shift, saturate, underflow, zero
        step(1'b1, (48'h1 << 46) | (48'h1 << 37), 0, 1'b1);
        step(1'b1, 48'h1 << 46, 3, 1'b1);
        step(1'b1, 48'hFFFF_FFFF_FFFF, 23, 1'b1);
        step(1'b1, 48'h1 << 46, -23, 1'b1);
        step(1'b1, 48'h0, 31, 1'b1);
        step(1'b1, 48'h1 << 45, -32, 1'b1);
        step(1'b1, 48'h3 << 36, 0, 1'b1);
        step(1'b0, '0, 0, 1'b0);
        drain();

        // Overflow: five pulses with the output stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, rand_q(), $urandom_range(0, 40) - 20, i < 4);
            check("fill_in_rdy", 64'(bus.in_rdy), (i < 4) ? 64'd1 : 64'd0);
        end
        step(1'b0, '0, 0, 1'b0);
        step(1'b0, '0, 0, 1'b0);
        step(1'b0, '0, 0, 1'b0);
        check("drop_err_set", 64'(drop_err), 64'd1);
        check("full_in_rdy", 64'(bus.in_rdy), 64'd0);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_quo_head", {31'd0, bus.sat, bus.quo}, 64'(exp_q[0]));
        step(1'b0, '0, 0, 1'b0);
        clr_err = 1'b1;
        step(1'b0, '0, 0, 1'b0);
        clr_err = 1'b0;
        check("drop_err_cleared", 64'(drop_err), 64'd0);
        check("stall_quo_stable", {31'd0, bus.sat, bus.quo}, 64'(exp_q[0]));

        // Drop coinciding with clear: the drop must remain visible
        step(1'b1, rand_q(), 0, 1'b0);
        step(1'b0, '0, 0, 1'b0);
        step(1'b0, '0, 0, 1'b0);
        clr_err = 1'b1;
        step(1'b0, '0, 0, 1'b0);
        clr_err = 1'b0;
        check("drop_beats_clear", 64'(drop_err), 64'd1);
        clr_err = 1'b1;
        step(1'b0, '0, 0, 1'b0);
        clr_err = 1'b0;
        check("drop_err_cleared2", 64'(drop_err), 64'd0);
        drain();

        // Continuous input with the sink always ready
        misses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rand_q(), $urandom_range(0, 63) - 32, 1'b1);
            if (i >= 3 && !bus.out_valid) misses++;
        end
        step(1'b0, '0, 0, 1'b0);
        check("stream_gaps", 64'(misses), 64'd0);
        drain();
        check("stream_no_drop", 64'(drop_err), 64'd0);

        // Random traffic, inputs issued only when in_rdy allows
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            v  = bus.in_rdy && ($urandom_range(0, 3) != 0);
            rq = rand_q();
            re = $urandom_range(0, 63) - 32;
            bus.q_valid = v;
            bus.q_in    = rq;
            bus.exp_in  = 6'(re);
            if (v) exp_q.push_back(model(rq, re));
        end
        step(1'b0, '0, 0, 1'b0);
        drain();
        check("random_no_drop", 64'(drop_err), 64'd0);

        // Reset with two results in the pipeline and two in the FIFO
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, rand_q(), 0, 1'b1);
        step(1'b0, '0, 0, 1'b0);
        check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_async_valid", 64'(bus.out_valid), 64'd0);
        check("reset_in_rdy", 64'(bus.in_rdy), 64'd0);
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, '0, 0, 1'b0);
        check("post_reset_valid", 64'(bus.out_valid), 64'd0);
        check("post_reset_drop", 64'(drop_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/newton_quot_denorm.md
NEWTON_QUOT_DENORM -- requirements
Module: newton_quot_denorm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and rst_n.
REQ-002 Parameter DSIZE, default 24: operand width of the Newton divider feeding this block.
REQ-003 Parameter FBITS, default 8: fraction bits of the output quotient; legal range 0..2*DSIZE-33.
REQ-004 Parameter DEPTH, default 4: output FIFO entries, power of two, minimum 2.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 q_in  in  2*DSIZE  divider mantissa Q, unsigned, 2*DSIZE-2 fraction bits.
REQ-008 exp_in  in  6  divider EXP, two's complement; quotient = Q*2^EXP.
REQ-009 q_valid  in  1  single-cycle pulse qualifying q_in/exp_in; the input cannot be stalled.
REQ-010 in_rdy  out  1  high when one more result is guaranteed a FIFO slot; gates the divider enable.
REQ-011 quo  out  DSIZE+FBITS  unsigned fixed-point quotient with FBITS fraction bits.
REQ-012 sat  out  1  quo was saturated; travels with quo.
REQ-013 out_valid / out_ready  out / in  1 / 1  valid/ready output handshake.
REQ-014 drop_err  out  1  sticky: an input was lost because the FIFO was full.
REQ-015 clr_err  in  1  synchronous clear of drop_err.

Function
REQ-016 Stage 1 SHALL register q_in and compute s = 2*DSIZE-2-FBITS-exp_in (signed exp_in, so s >= 0 always).
REQ-017 Stage 2 SHALL compute v = Q >> s (0 when s >= 2*DSIZE) and the round bit r = Q[s-1] (0 when s = 0 or s-1 >= 2*DSIZE).
REQ-018 Stage 3 SHALL form w = v + r and saturate.
  - If w >= 2^(DSIZE+FBITS): quo = all ones and sat = 1.
  - Otherwise: quo = w and sat = 0.
REQ-019 Rounding SHALL be round-half-up; Q = 0 SHALL yield quo = 0, sat = 0.
REQ-020 Latency SHALL be 3 cycles: a q_valid at cycle n writes the FIFO at the edge ending cycle n+2, and out_valid may first be seen in cycle n+3.
REQ-021 The pipeline SHALL accept back-to-back q_valid pulses, one per cycle.
REQ-022 The FIFO SHALL hold DEPTH {quo, sat} entries, pop on out_valid & out_ready, and keep order.
REQ-023 out_valid SHALL equal FIFO not empty; quo/sat SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Push and pop in the same cycle SHALL be legal at any count, and the count SHALL stay unchanged.
REQ-025 A push when the FIFO is full with no pop in the same cycle SHALL discard the entry and set drop_err.
REQ-026 drop_err SHALL stay set until clr_err; if clr_err and a new drop coincide, the drop SHALL win.
REQ-027 in_rdy SHALL be (FIFO count + valid pipeline stages) < DEPTH, registered, so it is conservative by one cycle.
REQ-028 Pointers SHALL wrap modulo DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-029 On rst_n low, asynchronously:
  - stage valids, FIFO pointers and drop_err SHALL reset to 0;
  - quo, sat and out_valid SHALL be 0;
  - in_rdy SHALL be 0 while rst_n is low and 1 from the first clock after release.
REQ-030 Reset during operation SHALL discard all in-flight and buffered results; no partial result SHALL appear after release.

Structure
REQ-031 A shared package SHALL hold the Q/EXP widths derived from DSIZE and the shift-amount width constant; the divider and this block both use it.
REQ-032 The FIFO SHALL be one sub-module, newton_quot_fifo; the shift, round and saturate logic stays in the top.

Verification (DSIZE=24, FBITS=8)
REQ-033 q_in=1<<46, exp_in=0 -> quo=0x00000100, sat=0, three cycles later.
REQ-034 q_in=(1<<46)|(1<<37), exp_in=0 -> quo=0x00000101 (round up); q_in=1<<46, exp_in=3 -> quo=0x00000800.
REQ-035 q_in=all ones, exp_in=23 -> quo=0xFFFFFFFF, sat=1; q_in=1<<46, exp_in=-23 -> quo=0, sat=0.
REQ-036 out_ready=0, 5 consecutive q_valid pulses -> 4 entries stored in order, 5th lost, drop_err=1; in_rdy low from the 4th accepted input; clr_err clears drop_err.
REQ-037 Continuous q_valid with out_ready=1 -> one result per cycle, no drops, count stable.
REQ-038 rst_n pulsed low while 2 results are in the pipeline and 2 in the FIFO -> out_valid=0 immediately; no stale output after release.
